wall_scheduler: RTL

WALL_SCHEDULER -- requirements
Module: wall_scheduler

---
 rtl/game_pkg.sv | 19 +
 rtl/wall_pick.sv | 29 ++
 rtl/wall_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the wall game scheduler.
//   NUM_WALLS_DEF    : default number of wall lanes
//   SPAWN_FRAMES_DEF : default frame ticks between spawn attempts
//   state_e          : scheduler FSM state encoding
package game_pkg;

    localparam int unsigned NUM_WALLS_DEF    = 4;
    localparam int unsigned SPAWN_FRAMES_DEF = 90;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StErase,
        StStep,
        StDraw,
        StOver
    } state_e;

endpackage

// File: rtl/wall_pick.sv
// Finds the lowest set bit of mask at or above index from.
//   mask  : candidate wall bits
//   from  : first index to consider (may equal NUM_WALLS, meaning none)
//   found : a candidate exists at or above from
//   idx   : index of that candidate (0 when none)
module wall_pick
    import game_pkg::*;
#(
    parameter int unsigned NUM_WALLS = NUM_WALLS_DEF,
    localparam int unsigned SelW     = $clog2(NUM_WALLS)
) (
    input  logic [NUM_WALLS-1:0] mask,
    input  logic [SelW:0]        from,
    output logic                 found,
    output logic [SelW-1:0]      idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_WALLS; i++) begin
            if (!found && mask[i] && (i >= 32'(from))) begin
                found = 1'b1;
                idx   = SelW'(i);
            end
        end
    end

endmodule

// File: rtl/wall_scheduler.sv
// Frame scheduler for a wall-dodging game: per frame tick it erases every live
// wall, advances them, optionally spawns one, then redraws them, sharing one
// draw engine through a req/done handshake.
//   clk, resetn              : clock, async active-low reset
//   go                       : start (IDLE) / restart (OVER) pulse
//   frame_tick               : frame strobe, accepted only in WAIT
//   touched, off_screen      : per-wall collision / reached-edge flags
//   draw_done                : draw engine finished current job
//   draw_req/erase/sel       : job request, type and wall index
//   wall_start, wall_step    : one-cycle spawn / advance pulses
//   wall_active, score       : live walls, saturating cleared count
//   game_over, frame_overrun : collision seen, tick dropped pulse
module wall_scheduler
    import game_pkg::*;
#(
    parameter int unsigned NUM_WALLS    = NUM_WALLS_DEF,
    parameter int unsigned SPAWN_FRAMES = SPAWN_FRAMES_DEF,
    localparam int unsigned SelW        = $clog2(NUM_WALLS)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 go,
    input  logic                 frame_tick,
    input  logic [NUM_WALLS-1:0] touched,
    input  logic [NUM_WALLS-1:0] off_screen,
    input  logic                 draw_done,
    output logic                 draw_req,
    output logic                 draw_erase,
    output logic [SelW-1:0]      draw_sel,
    output logic [NUM_WALLS-1:0] wall_start,
    output logic [NUM_WALLS-1:0] wall_step,
    output logic [NUM_WALLS-1:0] wall_active,
    output logic [7:0]           score,
    output logic                 game_over,
    output logic                 frame_overrun
);

    state_e               state_q;
    logic                 req_q, erase_q, over_q, overrun_q, hit_q;
    logic [SelW-1:0]      sel_q;
    logic [SelW:0]        from_q;  // next index the job walker may pick
    logic [NUM_WALLS-1:0] start_q, step_q, active_q;
    logic [7:0]           score_q, cnt_q;

    logic                 job_found, free_found;
    logic [SelW-1:0]      job_idx, free_idx;
    logic [NUM_WALLS-1:0] clears, spawn_vec;
    logic [3:0]           clear_cnt;
    logic [8:0]           score_sum;
    logic                 spawn_due, in_play, hit_now;

    wall_pick #(.NUM_WALLS(NUM_WALLS)) u_job_pick (
        .mask  (active_q),
        .from  (from_q),
        .found (job_found),
        .idx   (job_idx)
    );

    // Spawner looks at walls inactive at STEP entry, so a wall cleared in
    // this STEP is never the one respawned.
    wall_pick #(.NUM_WALLS(NUM_WALLS)) u_spawn_pick (
        .mask  (~active_q),
        .from  ('0),
        .found (free_found),
        .idx   (free_idx)
    );

    always_comb begin
        clears    = active_q & off_screen;
        clear_cnt = '0;
        for (int unsigned i = 0; i < NUM_WALLS; i++) begin
            clear_cnt = clear_cnt + 4'(clears[i]);
        end
        score_sum = {1'b0, score_q} + {5'b0, clear_cnt};
        spawn_due = (cnt_q >= 8'(SPAWN_FRAMES));
        spawn_vec = '0;
        if (spawn_due && free_found) begin
            spawn_vec[free_idx] = 1'b1;
        end
        in_play = (state_q == StWait) || (state_q == StErase) ||
                  (state_q == StStep) || (state_q == StDraw);
        hit_now = in_play && (|(touched & active_q));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            req_q     <= 1'b0;
            erase_q   <= 1'b0;
            sel_q     <= '0;
            from_q    <= '0;
            start_q   <= '0;
            step_q    <= '0;
            active_q  <= '0;
            score_q   <= '0;
            cnt_q     <= '0;
            over_q    <= 1'b0;
            overrun_q <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            start_q   <= '0;
            step_q    <= '0;
            overrun_q <= frame_tick &&
                         ((state_q == StErase) || (state_q == StStep) || (state_q == StDraw));
            if (hit_now) begin
                hit_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (go) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (frame_tick) begin
                        cnt_q   <= cnt_q + 8'd1;
                        from_q  <= '0;
                        state_q <= StErase;
                    end
                end
                StErase, StDraw: begin
                    if (req_q) begin
                        // Drop req for one cycle before the next job.
                        if (draw_done) begin
                            req_q  <= 1'b0;
                            from_q <= {1'b0, sel_q} + (SelW + 1)'(1);
                        end
                    end else if (job_found) begin
                        req_q   <= 1'b1;
                        sel_q   <= job_idx;
                        erase_q <= (state_q == StErase);
                    end else begin
                        from_q <= '0;
                        if (state_q == StErase) begin
                            state_q <= StStep;
                        end else if (hit_q || hit_now) begin
                            state_q <= StOver;
                            over_q  <= 1'b1;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StStep: begin
                    step_q   <= active_q;
                    start_q  <= spawn_vec;
                    active_q <= (active_q & ~clears) | spawn_vec;
                    score_q  <= score_sum[8] ? 8'hFF : score_sum[7:0];
                    if (spawn_due) begin
                        cnt_q <= '0;
                    end
                    state_q <= StDraw;
                end
                StOver: begin
                    if (go) begin
                        active_q <= '0;
                        score_q  <= '0;
                        cnt_q    <= '0;
                        hit_q    <= 1'b0;
                        over_q   <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign draw_req      = req_q;
    assign draw_erase    = erase_q;
    assign draw_sel      = sel_q;
    assign wall_start    = start_q;
    assign wall_step     = step_q;
    assign wall_active   = active_q;
    assign score         = score_q;
    assign game_over     = over_q;
    assign frame_overrun = overrun_q;

endmodule
